// File: rtl/ldpc_ber_counter.sv
// rtl/ldpc_ber_counter.sv - bit/block error counter for all-zero LDPC hard decisions
module ldpc_ber_counter #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  data_clk,
  input  logic                  data_resetn,
  input  logic                  data_en,
  input  logic                  data_sw_resetn,
  input  logic [DATA_WIDTH-1:0] data_last_mask,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [63:0]           data_finished_blocks,
  output logic [CNT_WIDTH-1:0]  data_bit_errors,
  output logic [CNT_WIDTH-1:0]  data_block_errors
);

  localparam int LANES = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  r_tready;
  logic                  w_accept;

  logic                  r_v1;
  logic                  r_last1;
  logic [DATA_WIDTH-1:0] r_d1;
  logic [127:0]          w_d1_ext;

  logic                  r_v2;
  logic                  r_last2;
  logic [5:0]            r_lane [LANES];
  logic [7:0]            w_lane_sum;

  logic                  r_v3;
  logic                  r_last3;
  logic [7:0]            r_c3;

  logic [63:0]           r_finished;
  logic [CNT_WIDTH-1:0]  r_bit_err;
  logic [CNT_WIDTH-1:0]  r_blk_err;
  logic [15:0]           r_blk_acc;
  logic [CNT_WIDTH:0]    w_bit_sum;
  logic [16:0]           w_acc_sum;

  function automatic logic [5:0] f_pop32(input logic [31:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, x[i]};
    end
    return n;
  endfunction

  assign w_accept   = s_axis_tvalid & r_tready;
  // Narrow widths zero-fill the upper lanes so they contribute nothing.
  assign w_d1_ext   = 128'(r_d1);
  assign w_lane_sum = {2'b00, r_lane[0]} + {2'b00, r_lane[1]}
                    + {2'b00, r_lane[2]} + {2'b00, r_lane[3]};
  assign w_bit_sum  = {1'b0, r_bit_err} + {{(CNT_WIDTH-7){1'b0}}, r_c3};
  assign w_acc_sum  = {1'b0, r_blk_acc} + {9'b0, r_c3};

  // Ready follows enable and the soft clear one cycle late.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= data_en & data_sw_resetn;
    end
  end

  // S1: capture the accepted beat, masking the last beat of a block.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_d1    <= '0;
    end else if (!data_sw_resetn) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_last1 <= s_axis_tlast;
        r_d1    <= s_axis_tdata & (s_axis_tlast ? data_last_mask : {DATA_WIDTH{1'b1}});
      end
    end
  end

  // S2: per-lane popcounts of the 32-bit slices.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
    end else if (!data_sw_resetn) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
    end else begin
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      for (int i = 0; i < LANES; i++) r_lane[i] <= f_pop32(w_d1_ext[i*32 +: 32]);
    end
  end

  // S3: fold lane counts into the per-beat error count.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_v3    <= 1'b0;
      r_last3 <= 1'b0;
      r_c3    <= '0;
    end else if (!data_sw_resetn) begin
      r_v3    <= 1'b0;
      r_last3 <= 1'b0;
    end else begin
      r_v3    <= r_v2;
      r_last3 <= r_last2;
      r_c3    <= w_lane_sum;
    end
  end

  // Counter update; a soft clear beats a colliding S3 update.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_finished <= '0;
      r_bit_err  <= '0;
      r_blk_err  <= '0;
      r_blk_acc  <= '0;
    end else if (!data_sw_resetn) begin
      r_finished <= '0;
      r_bit_err  <= '0;
      r_blk_err  <= '0;
      r_blk_acc  <= '0;
    end else if (r_v3) begin
      r_bit_err <= w_bit_sum[CNT_WIDTH] ? CNT_MAX : w_bit_sum[CNT_WIDTH-1:0];
      if (r_last3) begin
        r_finished <= r_finished + 64'd1;
        if ((w_acc_sum != 17'd0) && (r_blk_err != CNT_MAX)) begin
          r_blk_err <= r_blk_err + CNT_ONE;
        end
        r_blk_acc <= '0;
      end else begin
        r_blk_acc <= w_acc_sum[16] ? 16'hFFFF : w_acc_sum[15:0];
      end
    end
  end

  assign s_axis_tready        = r_tready;
  assign data_finished_blocks = r_finished;
  assign data_bit_errors      = r_bit_err;
  assign data_block_errors    = r_blk_err;

endmodule

// File: tb/tb_ldpc_ber_counter.sv
// tb/tb_ldpc_ber_counter.sv - self-checking bench for ldpc_ber_counter
module tb_ldpc_ber_counter;

  localparam int DW = 128;
  localparam int CW = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          data_clk = 1'b0;
  logic          data_resetn;
  logic          data_en;
  logic          data_sw_resetn;
  logic [DW-1:0] data_last_mask;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [63:0]   data_finished_blocks;
  logic [CW-1:0] data_bit_errors;
  logic [CW-1:0] data_block_errors;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  ldpc_ber_counter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .data_clk             (data_clk),
    .data_resetn          (data_resetn),
    .data_en              (data_en),
    .data_sw_resetn       (data_sw_resetn),
    .data_last_mask       (data_last_mask),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .data_finished_blocks (data_finished_blocks),
    .data_bit_errors      (data_bit_errors),
    .data_block_errors    (data_block_errors)
  );

  always #5 data_clk = ~data_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted beat becomes an event carrying its error
  // count, applied to the totals three edges after acceptance.
  typedef struct {
    longint due;
    int     cnt;
    bit     last;
  } ev_t;

  ev_t         q[$];
  longint      cyc = 0;
  bit          m_tready = 1'b0;
  logic [63:0] m_fin = '0;
  longint      m_bit = 0;
  longint      m_blk = 0;
  longint      m_acc = 0;

  initial begin
    ev_t e;
    forever begin
      @(posedge data_clk or negedge data_resetn);
      if (!data_resetn || !data_sw_resetn) begin
        q.delete();
        m_fin = '0; m_bit = 0; m_blk = 0; m_acc = 0;
        m_tready = 1'b0;
      end else if (data_clk) begin
        cyc++;
        while (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          m_bit = (m_bit + e.cnt > CMAX) ? CMAX : m_bit + e.cnt;
          if (e.last) begin
            m_fin = m_fin + 64'd1;
            if (m_acc + e.cnt != 0 && m_blk < CMAX) m_blk++;
            m_acc = 0;
          end else begin
            m_acc = (m_acc + e.cnt > 65535) ? 65535 : m_acc + e.cnt;
          end
        end
        if (s_axis_tvalid && m_tready) begin
          e.due  = cyc + 3;
          e.cnt  = $countones(s_axis_tdata & (s_axis_tlast ? data_last_mask : {DW{1'b1}}));
          e.last = s_axis_tlast;
          q.push_back(e);
        end
        m_tready = data_en;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge data_clk);
      if (cmp_on) begin
        chk("m_tready",  {63'd0, s_axis_tready}, {63'd0, m_tready});
        chk("m_finished", data_finished_blocks, m_fin);
        chk("m_bit_err", 64'(data_bit_errors), 64'(m_bit));
        chk("m_blk_err", 64'(data_block_errors), 64'(m_blk));
      end
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic l);
    @(negedge data_clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge data_clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic sw_clear();
    @(negedge data_clk);
    s_axis_tvalid  = 1'b0;
    data_sw_resetn = 1'b0;
    @(negedge data_clk);
    data_sw_resetn = 1'b1;
  endtask

  task automatic totals(input string tag, input logic [63:0] fin, input logic [63:0] be,
                        input logic [63:0] ble);
    chk({tag, "_finished"}, data_finished_blocks, fin);
    chk({tag, "_bit_err"}, 64'(data_bit_errors), be);
    chk({tag, "_blk_err"}, 64'(data_block_errors), ble);
  endtask

  logic [DW-1:0] ones;

  initial begin
    ones           = '1;
    data_resetn    = 1'b0;
    data_en        = 1'b0;
    data_sw_resetn = 1'b1;
    data_last_mask = '1;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;

    // Reset state
    repeat (3) @(negedge data_clk);
    cmp_on = 1'b1;
    @(negedge data_clk);
    totals("rst", 64'd0, 64'd0, 64'd0);
    chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    data_resetn = 1'b1;
    data_en     = 1'b1;
    chk("rel_tready0", {63'd0, s_axis_tready}, 64'd0);
    @(negedge data_clk);
    chk("rel_tready1", {63'd0, s_axis_tready}, 64'd1);

    // Clean block, update lands exactly three edges after the last accept
    beat('0, 1'b0); beat('0, 1'b0); beat('0, 1'b0); beat('0, 1'b1);
    idle(1);
    @(negedge data_clk); @(negedge data_clk);
    chk("clean_latency_early", data_finished_blocks, 64'd0);
    @(negedge data_clk);
    totals("clean", 64'd1, 64'd0, 64'd0);

    // Errored block with last-beat mask: 1 + 4 + 128 + 8
    sw_clear();
    data_last_mask = 128'hFF;
    beat(128'h1, 1'b0); beat(128'hF0, 1'b0); beat(ones, 1'b0); beat(ones, 1'b1);
    idle(6);
    totals("err", 64'd1, 64'd141, 64'd1);

    // Saturation: 511 full beats reach 0xFF80, one more clamps
    sw_clear();
    data_last_mask = '1;
    for (int i = 0; i < 511; i++) beat(ones, 1'b0);
    idle(6);
    chk("sat_pre", 64'(data_bit_errors), 64'hFF80);
    beat(ones, 1'b1);
    idle(6);
    totals("sat", 64'd1, CMAX, 64'd1);
    beat(ones, 1'b1);
    idle(6);
    totals("sat_hold", 64'd2, CMAX, 64'd2);

    // Soft clear right behind an accepted last beat with 5 errors
    beat(128'h1F, 1'b1);
    @(negedge data_clk);
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    data_sw_resetn = 1'b0;
    @(negedge data_clk);
    data_sw_resetn = 1'b1;
    chk("swr_tready_low", {63'd0, s_axis_tready}, 64'd0);
    @(negedge data_clk);
    chk("swr_tready_back", {63'd0, s_axis_tready}, 64'd1);
    idle(6);
    totals("swr", 64'd0, 64'd0, 64'd0);

    // Enable gap mid-block: junk offered while not ready is ignored
    beat(128'h7, 1'b0); beat(128'h700, 1'b0);
    @(negedge data_clk);
    s_axis_tvalid = 1'b0;
    data_en       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge data_clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = ones;
      s_axis_tlast  = 1'b1;
      chk("gap_tready", {63'd0, s_axis_tready}, 64'd0);
    end
    @(negedge data_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    data_en       = 1'b1;
    beat('0, 1'b1);
    idle(6);
    totals("gap", 64'd1, 64'd6, 64'd1);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
